// File: rtl/instr_decode_queue_if.sv
// instr_decode_queue_if: fetch-side and execute-side handshake bundle for the decode queue
// master drives in_valid/instr/out_ready; slave (the queue) drives everything else
interface instr_decode_queue_if #(
  parameter int OP_W = 4,
  parameter int PARAM_W = 6,
  parameter int DEPTH = 4
);
  localparam int INSTR_W = OP_W + 2*PARAM_W;
  logic in_valid;
  logic in_ready;
  logic [INSTR_W-1:0] instr;
  logic out_valid;
  logic out_ready;
  logic [OP_W-1:0] state;
  logic [PARAM_W-1:0] parameter1;
  logic [PARAM_W-1:0] parameter2;
  logic [INSTR_W-1:0] imm;
  logic has_imm;
  logic illegal;
  logic [$clog2(DEPTH):0] level;
  modport master (
    output in_valid, instr, out_ready,
    input in_ready, out_valid, state, parameter1, parameter2, imm, has_imm, illegal, level
  );
  modport slave (
    input in_valid, instr, out_ready,
    output in_ready, out_valid, state, parameter1, parameter2, imm, has_imm, illegal, level
  );
endinterface

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: decodes instruction words (with optional immediate word) into a DEPTH-deep FIFO
// clk/reset (async, active-high), flush (sync clear of FIFO and FSM)
// bus.in_valid/in_ready/instr: word input; bus.out_valid/out_ready: head handshake
// bus.state/parameter1/parameter2/imm/has_imm/illegal: head fields (0 when empty); bus.level: occupancy
module instr_decode_queue #(
  parameter int OP_W = 4,
  parameter int PARAM_W = 6,
  parameter int DEPTH = 4,
  parameter logic [2**OP_W-1:0] LONG_OP_MASK = 16'h8000,
  parameter logic [2**OP_W-1:0] ILLEGAL_MASK = 16'h4000
) (
  input logic clk,
  input logic reset,
  input logic flush,
  instr_decode_queue_if.slave bus
);
  localparam int INSTR_W = OP_W + 2*PARAM_W;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*INSTR_W + 2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {S_OP, S_EXT} fsm_t;
  fsm_t st, st_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] ent, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [INSTR_W-1:0] pend, hw;
  logic [OP_W-1:0] op, pend_op;
  logic acc, pop, push, is_long;
  assign op = bus.instr[INSTR_W-1 -: OP_W];
  assign pend_op = pend[INSTR_W-1 -: OP_W];
  assign bus.in_ready = (cnt < FULL) && !flush;
  assign bus.out_valid = cnt != '0;
  assign bus.level = cnt;
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign head = bus.out_valid ? mem[rd_ptr] : '0;
  assign {hw, bus.imm, bus.has_imm, bus.illegal} = head;
  assign bus.state = hw[INSTR_W-1 -: OP_W];
  assign bus.parameter1 = hw[2*PARAM_W-1 -: PARAM_W];
  assign bus.parameter2 = hw[PARAM_W-1:0];
  always_comb begin
    is_long = LONG_OP_MASK[op];
    push = acc && (st == S_EXT || !is_long);
    ent = st == S_EXT ? {pend, bus.instr, 1'b1, ILLEGAL_MASK[pend_op]}
                      : {bus.instr, {INSTR_W{1'b0}}, 1'b0, ILLEGAL_MASK[op]};
    st_nx = flush ? S_OP : !acc ? st : (st == S_OP && is_long) ? S_EXT : S_OP;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= S_OP;
    else st <= st_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      pend <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      pend <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (acc && st == S_OP && is_long) pend <= bus.instr;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= ent;
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: randomized and directed checks of instr_decode_queue against a queue-based model
module tb_instr_decode_queue;
  typedef struct {
    logic [15:0] w;
    logic [15:0] imm;
    logic h;
    logic il;
  } ent_t;
  logic clk = 0;
  logic reset = 1;
  logic flush = 0;
  int n_chk = 0;
  int n_fail = 0;
  ent_t q[$];
  bit want = 0;
  logic [15:0] pend = 0;
  logic [15:0] long_mask = 16'h8000;
  logic [15:0] ill_mask = 16'h4000;
  instr_decode_queue_if #(.OP_W(4), .PARAM_W(6), .DEPTH(4)) bus();
  instr_decode_queue #(.OP_W(4), .PARAM_W(6), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    ent_t e;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("level", 32'(bus.level), 32'(q.size()));
    if (q.size() != 0) e = q[0];
    else e = '{w: 16'h0, imm: 16'h0, h: 1'b0, il: 1'b0};
    chk("state", 32'(bus.state), 32'(e.w[15:12]));
    chk("parameter1", 32'(bus.parameter1), 32'(e.w[11:6]));
    chk("parameter2", 32'(bus.parameter2), 32'(e.w[5:0]));
    chk("imm", 32'(bus.imm), 32'(e.imm));
    chk("has_imm", 32'(bus.has_imm), 32'(e.h));
    chk("illegal", 32'(bus.illegal), 32'(e.il));
  endtask
  task automatic model_clear();
    q.delete();
    want = 0;
    pend = 0;
  endtask
  task automatic step(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
    logic er;
    ent_t e;
    bus.in_valid = v;
    bus.instr = w;
    bus.out_ready = ordy;
    flush = fl;
    #3;
    er = (q.size() < 4) && !fl;
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    if (fl) model_clear();
    else begin
      if (q.size() != 0 && ordy) e = q.pop_front();
      if (v && er) begin
        if (want) begin
          q.push_back('{w: pend, imm: w, h: 1'b1, il: ill_mask[pend[15:12]]});
          want = 0;
        end else if (long_mask[w[15:12]]) begin
          pend = w;
          want = 1;
        end else q.push_back('{w: w, imm: 16'h0, h: 1'b0, il: ill_mask[w[15:12]]});
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    reset = 1;
    #2;
    chk("async_level", 32'(bus.level), 32'd0);
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    check_all();
  endtask
  function automatic logic [15:0] short_word();
    return {4'($urandom_range(0, 14)), 12'($urandom)};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid = 0;
    bus.instr = 0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_all();
    step(1, 16'h1042, 0, 0);
    chk("t1_state", 32'(bus.state), 32'd1);
    chk("t1_p1", 32'(bus.parameter1), 32'd1);
    chk("t1_p2", 32'(bus.parameter2), 32'd2);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, short_word(), 0, 0);
    chk("t2_full", 32'(bus.in_ready), 32'd0);
    step(1, 16'h5555, 0, 0);
    step(1, 16'h5555, 1, 0);
    step(1, 16'h5555, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0, 1, 0);
    step(1, 16'hF0C3, 0, 0);
    chk("t3_no_push", 32'(bus.level), 32'd0);
    step(1, 16'hBEEF, 0, 0);
    chk("t3_state", 32'(bus.state), 32'hF);
    chk("t3_imm", 32'(bus.imm), 32'hBEEF);
    step(0, 16'h0, 1, 0);
    step(1, 16'hE001, 0, 0);
    chk("t4_illegal", 32'(bus.illegal), 32'd1);
    step(1, 16'h2000, 1, 0);
    chk("t4_next_legal", 32'(bus.illegal), 32'd0);
    step(0, 16'h0, 1, 0);
    step(1, short_word(), 0, 0);
    step(1, short_word(), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, short_word(), 1, 0);
      chk("t5_level", 32'(bus.level), 32'd2);
    end
    step(1, 16'hF000, 0, 0);
    step(0, 16'h0, 0, 1);
    chk("t6_flush_level", 32'(bus.level), 32'd0);
    step(1, 16'h3000, 0, 0);
    chk("t6_flush_op", 32'(bus.state), 32'd3);
    step(1, 16'hF000, 0, 0);
    do_reset();
    step(1, 16'h3000, 0, 0);
    chk("t6_reset_op", 32'(bus.state), 32'd3);
    chk("t6_reset_has_imm", 32'(bus.has_imm), 32'd0);
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) do_reset();
      step(logic'($urandom_range(0, 3) != 0), 16'($urandom), logic'($urandom_range(0, 2) != 0),
           logic'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
